// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory with wait states and a Ready/AddrErr handshake
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        AddrErr,
    output logic        Busy
);

    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nxt;

    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              rd_q;
    logic              wr_q;
    logic              err_q;

    logic [31:0]       mem [DEPTH_WORDS];

    logic              idle_s;
    logic              req;
    logic [31:0]       op_addr;
    logic [31:0]       op_wdata;
    logic              op_rd;
    logic              op_wr;
    logic [IDX_W-1:0]  op_idx;
    logic              op_err;
    logic              enter_resp;
    logic              mem_we;

    assign idle_s = (state == S_IDLE);
    assign req    = MemRead | MemWrite;

    // With zero wait states the access completes on the acceptance edge itself,
    // so the operands come straight from the inputs while idle and from the
    // latched copies otherwise.
    assign op_addr  = idle_s ? Addr      : addr_q;
    assign op_wdata = idle_s ? WriteData : wdata_q;
    assign op_rd    = idle_s ? MemRead   : rd_q;
    assign op_wr    = idle_s ? MemWrite  : wr_q;

    assign op_idx = op_addr[IDX_W+1:2];
    assign op_err = (op_addr[1:0] != 2'b00)
                  | (|op_addr[31:IDX_W+2])
                  | (op_rd & op_wr);

    assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);
    // Gated by reset so a request presented while reset is held cannot store.
    assign mem_we     = reset & enter_resp & op_wr & ~op_err;

    assign Ready   = (state == S_RESP);
    assign AddrErr = (state == S_RESP) & err_q;
    assign Busy    = (state != S_IDLE);

    // Next-state and wait counter sequencing
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (req) begin
                    cnt_nxt = CNT_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and counter registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the request only when it is accepted; later input changes are ignored
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else if (idle_s && req) begin
            addr_q  <= Addr;
            wdata_q <= WriteData;
            rd_q    <= MemRead;
            wr_q    <= MemWrite;
        end
    end

    // Response data and error flag, updated on the edge entering RESP
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            err_q    <= 1'b0;
            ReadData <= 32'd0;
        end else if (enter_resp) begin
            err_q <= op_err;
            if (op_err) begin
                ReadData <= 32'd0;
            end else if (!op_wr) begin
                ReadData <= mem[op_idx];
            end
        end
    end

    // Storage array: synchronous write, no reset so contents survive reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[op_idx] <= op_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic        CLK;
    logic        rst_n     [2];
    logic        mem_read  [2];
    logic        mem_write [2];
    logic [31:0] addr      [2];
    logic [31:0] wdata     [2];
    logic [31:0] rdata     [2];
    logic        ready     [2];
    logic        addr_err  [2];
    logic        busy      [2];

    int tests = 0;
    int fails = 0;

    // Reference model: flat word arrays and the last value presented on ReadData
    int          depth_m [2];
    int          wait_m  [2];
    logic [31:0] mem_m   [2][4096];
    logic [31:0] last_rd [2];

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
        .CLK       (CLK),
        .reset     (rst_n[0]),
        .MemRead   (mem_read[0]),
        .MemWrite  (mem_write[0]),
        .Addr      (addr[0]),
        .WriteData (wdata[0]),
        .ReadData  (rdata[0]),
        .Ready     (ready[0]),
        .AddrErr   (addr_err[0]),
        .Busy      (busy[0])
    );

    data_mem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut0 (
        .CLK       (CLK),
        .reset     (rst_n[1]),
        .MemRead   (mem_read[1]),
        .MemWrite  (mem_write[1]),
        .Addr      (addr[1]),
        .WriteData (wdata[1]),
        .ReadData  (rdata[1]),
        .Ready     (ready[1]),
        .AddrErr   (addr_err[1]),
        .Busy      (busy[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_idle(input int w);
        mem_read[w]  = 1'b0;
        mem_write[w] = 1'b0;
        addr[w]      = 32'd0;
        wdata[w]     = 32'd0;
    endtask

    // Caller is at a falling edge with the DUT idle; returns at a falling edge, idle again.
    task automatic access(input int w, input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input bit garbage,
                          output logic err, output logic [31:0] rdat, output int lat);
        mem_read[w]  = rd;
        mem_write[w] = wr;
        addr[w]      = a;
        wdata[w]     = wd;
        @(posedge CLK);
        @(negedge CLK);
        lat = 1;
        check("busy_after_accept", 32'(busy[w]), 32'd1);
        drive_idle(w);
        while (ready[w] !== 1'b1 && lat < 40) begin
            if (garbage) begin
                mem_read[w]  = 1'($urandom);
                mem_write[w] = 1'($urandom);
                addr[w]      = $urandom;
                wdata[w]     = $urandom;
            end
            @(negedge CLK);
            lat++;
        end
        err  = addr_err[w];
        rdat = rdata[w];
        drive_idle(w);
        @(negedge CLK);
        check("ready_one_cycle", 32'(ready[w]), 32'd0);
        check("idle_after_resp", 32'(busy[w]), 32'd0);
    endtask

    task automatic model(input int w, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, output logic exp_err, output logic [31:0] exp_rd);
        exp_err = (a % 4 != 0) || (a >= 32'(depth_m[w] * 4)) || (rd && wr);
        if (exp_err) begin
            last_rd[w] = 32'd0;
        end else if (wr) begin
            mem_m[w][a / 4] = wd;
        end else begin
            last_rd[w] = mem_m[w][a / 4];
        end
        exp_rd = last_rd[w];
    endtask

    task automatic run_checked(input int w, input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] wd, input bit garbage);
        logic        err;
        logic [31:0] rdat;
        int          lat;
        logic        e_err;
        logic [31:0] e_rd;
        access(w, rd, wr, a, wd, garbage, err, rdat, lat);
        model(w, rd, wr, a, wd, e_err, e_rd);
        check("latency", 32'(lat), 32'(wait_m[w] + 1));
        check("addr_err", 32'(err), 32'(e_err));
        check("read_data", rdat, e_rd);
    endtask

    function automatic logic [31:0] rand_addr(input int d);
        int sel;
        sel = int'($urandom_range(0, 5));
        case (sel)
            0, 1, 2: return 32'($urandom_range(0, d - 1)) * 32'd4;
            3:       return 32'($urandom_range(0, d - 1)) * 32'd4 + 32'($urandom_range(1, 3));
            4:       return $urandom | 32'h8000_0000;
            default: return ($urandom_range(0, 1) == 0) ? 32'((d - 1) * 4)
                                                         : 32'(d * 4) + 32'($urandom_range(0, 3)) * 32'd4;
        endcase
    endfunction

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    initial begin
        logic        err;
        logic [31:0] rdat;
        int          lat;
        logic        e_err;
        logic [31:0] e_rd;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0012, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0012, 32'h0000_0001, 1'b1, 32'h0000_0000};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, 1'b1, 32'h0000_0000};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h0000_0BAD, 1'b1, 32'h0000_0000};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hCAFE_F00D};
        vecs[10] = '{1'b0, 1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 1'b0, 32'hCAFE_F00D};
        vecs[11] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, 1'b0, 32'hA5A5_A5A5};
        vecs[12] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[13] = '{1'b0, 1'b1, 32'h0000_0020, 32'h0000_0077, 1'b0, 32'h0000_0000};

        depth_m[0] = 256; wait_m[0] = 2;
        depth_m[1] = 16;  wait_m[1] = 0;
        for (int w = 0; w < 2; w++) begin
            rst_n[w]   = 1'b0;
            last_rd[w] = 32'd0;
            drive_idle(w);
        end

        // Reset state
        repeat (3) @(negedge CLK);
        for (int w = 0; w < 2; w++) begin
            check("rst_read_data", rdata[w], 32'd0);
            check("rst_ready", 32'(ready[w]), 32'd0);
            check("rst_addr_err", 32'(addr_err[w]), 32'd0);
            check("rst_busy", 32'(busy[w]), 32'd0);
        end
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // Fill storage with known contents (first request lands on the first edge out of reset)
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < depth_m[w]; i++) begin
                run_checked(w, 1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0);
            end
        end

        // Directed table on the two-wait-state instance
        for (int i = 0; i < 14; i++) begin
            access(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, err, rdat, lat);
            model(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, e_err, e_rd);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
            check($sformatf("vec%0d_addr_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_read_data", i), rdat, vecs[i].exp_rdata);
        end

        // Reset pulsed while a write of 0x55 to 0x20 is in BUSY
        mem_write[0] = 1'b1;
        addr[0]      = 32'h20;
        wdata[0]     = 32'h55;
        @(posedge CLK);
        @(negedge CLK);
        check("abort_busy_before", 32'(busy[0]), 32'd1);
        drive_idle(0);
        rst_n[0] = 1'b0;
        #1;
        check("abort_busy_now", 32'(busy[0]), 32'd0);
        check("abort_ready_now", 32'(ready[0]), 32'd0);
        check("abort_read_data", rdata[0], 32'd0);
        #2;
        rst_n[0] = 1'b1;
        last_rd[0] = 32'd0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge CLK);
                if (ready[0] === 1'b1) seen++;
            end
            check("abort_no_ready", 32'(seen), 32'd0);
        end
        access(0, 1'b1, 1'b0, 32'h20, 32'd0, 1'b0, err, rdat, lat);
        model(0, 1'b1, 1'b0, 32'h20, 32'd0, e_err, e_rd);
        check("abort_readback", rdat, 32'h0000_0077);
        check("abort_readback_err", 32'(err), 32'd0);

        // Zero wait states: a held read is re-accepted every second cycle
        mem_read[1] = 1'b1;
        addr[1]     = 32'h4;
        @(posedge CLK);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check($sformatf("ws0_ready_%0d", i), 32'(ready[1]), 32'((i % 2) == 0));
        end
        drive_idle(1);
        model(1, 1'b1, 1'b0, 32'h4, 32'd0, e_err, e_rd);
        check("ws0_read_data", rdata[1], e_rd);
        check("ws0_addr_err", 32'(addr_err[1]), 32'd0);

        // Randomized traffic with junk on the inputs while busy
        for (int n = 0; n < 200; n++) begin
            for (int w = 0; w < 2; w++) begin
                int  kind;
                bit  rd;
                bit  wr;
                kind = int'($urandom_range(0, 9));
                rd   = (kind < 4) || (kind >= 8);
                wr   = (kind >= 4);
                run_checked(w, rd, wr, rand_addr(depth_m[w]), $urandom, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
